oled_spi_streamer: RTL and testbench

OLED_SPI_STREAMER -- requirements
Module: oled_spi_streamer

---
 rtl/oled_spi_streamer_pkg.sv | 16 +
 rtl/oled_init_rom.sv | 18 +
 rtl/oled_spi_streamer.sv | 124 ++++++++++++
 tb/tb_oled_spi_streamer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/oled_spi_streamer_pkg.sv
// oled_spi_streamer_pkg: shared FSM encoding, frame size and default parameter values
package oled_spi_streamer_pkg;
  localparam int FRAME_BYTES    = 1024;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_RES_CYCLES = 1000;
  localparam int DEF_INIT_LEN   = 25;
  typedef enum logic [2:0] {
    PANEL_RST,
    INIT_FETCH,
    INIT_SHIFT,
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;
endpackage

// File: rtl/oled_init_rom.sv
// oled_init_rom: combinational panel init command table, display-off first and display-on last
module oled_init_rom
  import oled_spi_streamer_pkg::*;
#(
  parameter int INIT_LEN = DEF_INIT_LEN
) (
  input  logic [7:0] idx_i,
  output logic [7:0] data_o
);
  localparam logic [7:0] LAST = 8'(INIT_LEN - 1);
  localparam logic [7:0] TBL [24] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
    8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
    8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6
  };
  // Last index is always display-on; entries past the table pad with NOP
  assign data_o = (idx_i == LAST) ? 8'hAF : (idx_i < 8'd24) ? TBL[idx_i[4:0]] : 8'hE3;
endmodule

// File: rtl/oled_spi_streamer.sv
// oled_spi_streamer: resets and initialises an SPI OLED panel, then streams 1024-byte frames on request
module oled_spi_streamer
  import oled_spi_streamer_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int RES_CYCLES = DEF_RES_CYCLES,
  parameter int INIT_LEN   = DEF_INIT_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_frame,
  input  logic [7:0] data_to_send,
  output logic [9:0] byte_counter,
  output logic       busy,
  output logic       frame_done,
  output logic       oled_sclk,
  output logic       oled_mosi,
  output logic       oled_cs_n,
  output logic       oled_dc,
  output logic       oled_res_n
);
  localparam logic [31:0] RES_LAST  = 32'(RES_CYCLES - 1);
  localparam logic [31:0] DIV_LAST  = 32'(CLK_DIV - 1);
  localparam logic [7:0]  INIT_LAST = 8'(INIT_LEN - 1);
  localparam logic [9:0]  BC_LAST   = 10'(FRAME_BYTES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  half_q, half_d;
  logic        ph_q, ph_d, pend_q, pend_d;
  logic [7:0]  idx_q, idx_d, sr_q, sr_d, rom_byte;
  logic [9:0]  bc_q, bc_d;
  logic        pre_idle, in_fetch, in_shift, half_end, byte_end;

  oled_init_rom #(.INIT_LEN(INIT_LEN)) u_rom (
    .idx_i  (idx_q),
    .data_o (rom_byte)
  );

  assign pre_idle = state_q inside {PANEL_RST, INIT_FETCH, INIT_SHIFT};
  assign in_fetch = state_q inside {INIT_FETCH, FETCH};
  assign in_shift = state_q inside {INIT_SHIFT, SHIFT};
  assign half_end = cnt_q == DIV_LAST;
  assign byte_end = half_end && half_q == 4'hf;

  // Next state: reset timer, two-cycle fetch, sixteen SCLK half-periods per byte, frame bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    ph_d    = ph_q;
    idx_d   = idx_q;
    bc_d    = bc_q;
    sr_d    = sr_q;
    pend_d  = pend_q | (start_frame & pre_idle);
    case (state_q)
      PANEL_RST: begin
        cnt_d   = (cnt_q == RES_LAST) ? '0 : cnt_q + 32'd1;
        state_d = (cnt_q == RES_LAST) ? INIT_FETCH : PANEL_RST;
      end
      INIT_FETCH, FETCH: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          sr_d    = (state_q == FETCH) ? data_to_send : rom_byte;
          state_d = (state_q == FETCH) ? SHIFT : INIT_SHIFT;
        end
      end
      INIT_SHIFT, SHIFT: begin
        cnt_d  = half_end ? '0 : cnt_q + 32'd1;
        half_d = half_end ? half_q + 4'd1 : half_q;
        sr_d   = (half_end && half_q[0]) ? {sr_q[6:0], 1'b0} : sr_q;
        if (byte_end && state_q == INIT_SHIFT) begin
          idx_d   = (idx_q == INIT_LAST) ? idx_q : idx_q + 8'd1;
          state_d = (idx_q == INIT_LAST) ? IDLE : INIT_FETCH;
        end
        if (byte_end && state_q == SHIFT) begin
          bc_d    = (bc_q == BC_LAST) ? bc_q : bc_q + 10'd1;
          state_d = (bc_q == BC_LAST) ? DONE : FETCH;
        end
      end
      IDLE: begin
        if (start_frame || pend_q) begin
          bc_d    = '0;
          pend_d  = 1'b0;
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = PANEL_RST;
    endcase
  end

  // State register; reset aborts any byte in flight and restarts the panel sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PANEL_RST;
      cnt_q   <= '0;
      half_q  <= '0;
      ph_q    <= 1'b0;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      bc_q    <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      ph_q    <= ph_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      bc_q    <= bc_d;
      sr_q    <= sr_d;
    end
  end

  assign byte_counter = bc_q;
  assign busy         = state_q != IDLE;
  assign frame_done   = state_q == DONE;
  assign oled_sclk    = in_shift & half_q[0];
  assign oled_mosi    = sr_q[7];
  assign oled_cs_n    = ~(in_fetch | in_shift);
  assign oled_dc      = state_q inside {FETCH, SHIFT};
  assign oled_res_n   = state_q != PANEL_RST;
endmodule

// File: tb/tb_oled_spi_streamer.sv
// tb_oled_spi_streamer: three concurrent instances checked by an SPI decoder and frame reference model
module tb_oled_spi_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n_a, rst_n_b, rst_n_c, st_a, st_b, st_c;
  logic done_a = 1'b0, done_b = 1'b0, done_c = 1'b0;
  logic rst_v [3];
  logic [9:0] bc [3];
  logic busy [3], fd [3], sclk [3], mosi [3], cs_n [3], dc [3], res_n [3];
  logic [7:0] dts [3];

  assign rst_v[0] = rst_n_a;
  assign rst_v[1] = rst_n_b;
  assign rst_v[2] = rst_n_c;

  oled_spi_streamer #(.CLK_DIV(2), .RES_CYCLES(10)) u_a (
    .clk(clk), .rst_n(rst_n_a), .start_frame(st_a), .data_to_send(dts[0]),
    .byte_counter(bc[0]), .busy(busy[0]), .frame_done(fd[0]), .oled_sclk(sclk[0]),
    .oled_mosi(mosi[0]), .oled_cs_n(cs_n[0]), .oled_dc(dc[0]), .oled_res_n(res_n[0]));
  oled_spi_streamer #(.CLK_DIV(4), .RES_CYCLES(10)) u_b (
    .clk(clk), .rst_n(rst_n_b), .start_frame(st_b), .data_to_send(dts[1]),
    .byte_counter(bc[1]), .busy(busy[1]), .frame_done(fd[1]), .oled_sclk(sclk[1]),
    .oled_mosi(mosi[1]), .oled_cs_n(cs_n[1]), .oled_dc(dc[1]), .oled_res_n(res_n[1]));
  oled_spi_streamer #(.CLK_DIV(2), .RES_CYCLES(10)) u_c (
    .clk(clk), .rst_n(rst_n_c), .start_frame(st_c), .data_to_send(dts[2]),
    .byte_counter(bc[2]), .busy(busy[2]), .frame_done(fd[2]), .oled_sclk(sclk[2]),
    .oled_mosi(mosi[2]), .oled_cs_n(cs_n[2]), .oled_dc(dc[2]), .oled_res_n(res_n[2]));

  // Image controller: registers the requested address' low byte
  always @(posedge clk)
    for (int i = 0; i < 3; i++) dts[i] <= bc[i][7:0];

  int nvec, nerr;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int nb [3], bitn [3], nfd [3], viol [3], ncs [3];
  logic [7:0] sr [3];
  logic ps [3] = '{1'b0, 1'b0, 1'b0};
  logic pm [3] = '{1'b0, 1'b0, 1'b0};
  logic pc [3] = '{1'b1, 1'b1, 1'b1};
  logic [7:0] bv [3][2200];
  logic bd [3][2200];
  int bt [3][2200];

  // SPI mode-0 receiver per instance, plus protocol watchers
  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      if (!rst_v[i]) bitn[i] = 0;
      else if (sclk[i] && !ps[i]) begin
        sr[i] = {sr[i][6:0], mosi[i]};
        bitn[i]++;
        if (bitn[i] == 8) begin
          if (nb[i] < 2200) begin
            bv[i][nb[i]] = sr[i];
            bd[i][nb[i]] = dc[i];
            bt[i][nb[i]] = cyc;
          end
          nb[i]++;
          bitn[i] = 0;
        end
      end
      if ((sclk[i] && ps[i] && mosi[i] != pm[i]) || (sclk[i] && cs_n[i])) viol[i]++;
      if (fd[i]) nfd[i]++;
      if (cs_n[i] && !pc[i]) ncs[i]++;
      ps[i] = sclk[i];
      pm[i] = mosi[i];
      pc[i] = cs_n[i];
    end

  function automatic int frame_errs(input int i, input int base);
    int e = 0;
    for (int k = 0; k < 1024; k++)
      if (bv[i][base + k] != 8'(k % 256) || bd[i][base + k] != 1'b1) e++;
    return e;
  endfunction

  localparam logic [31:0] RST_OUTS = {15'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  // Instance A: init with pending request, mid-frame pulses, two frames
  initial begin : scen_a
    int n, e;
    rst_n_a = 1'b0;
    st_a = 1'b0;
    repeat (3) @(negedge clk);
    check("a_reset_outs", 32'({bc[0], busy[0], fd[0], sclk[0], mosi[0], cs_n[0], dc[0], res_n[0]}), RST_OUTS);
    rst_n_a = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!res_n[0] && n < 100);
    check("a_res_low_cycles", n, 10);
    repeat (50) @(negedge clk);
    st_a = 1'b1; @(negedge clk); st_a = 1'b0;
    repeat (200) @(negedge clk);
    st_a = 1'b1; @(negedge clk); st_a = 1'b0;
    n = 0;
    while (busy[0] && n < 2000) begin @(negedge clk); n++; end
    check("a_init_idle", 32'(busy[0]), 0);
    check("a_init_count", nb[0], 25);
    check("a_init_first", 32'(bv[0][0]), 32'hAE);
    check("a_init_last", 32'(bv[0][24]), 32'hAF);
    e = 0;
    for (int k = 0; k < 25; k++) e += int'(bd[0][k]);
    check("a_init_dc", e, 0);
    check("a_init_period", bt[0][1] - bt[0][0], 34);
    @(negedge clk);
    check("a_pending_start", 32'({bc[0], cs_n[0], dc[0]}), 32'b01);
    n = 0;
    while (nb[0] < 325 && n < 20000) begin @(negedge clk); n++; end
    st_a = 1'b1; @(negedge clk); st_a = 1'b0;
    n = 0;
    while (nb[0] < 725 && n < 20000) begin @(negedge clk); n++; end
    st_a = 1'b1; @(negedge clk); st_a = 1'b0;
    n = 0;
    while (nfd[0] < 1 && n < 40000) begin @(negedge clk); n++; end
    repeat (300) @(negedge clk);
    check("a_one_frame_done", nfd[0], 1);
    check("a_frame_bytes", nb[0], 25 + 1024);
    check("a_idle_after_frame", 32'(busy[0]), 0);
    check("a_bc_hold", 32'(bc[0]), 1023);
    check("a_cs_rises", ncs[0], 2);
    check("a_frame1_data", frame_errs(0, 25), 0);
    check("a_frame_period", bt[0][26] - bt[0][25], 34);
    st_a = 1'b1; @(negedge clk); st_a = 1'b0;
    n = 0;
    while (nfd[0] < 2 && n < 40000) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    check("a_two_frame_done", nfd[0], 2);
    check("a_total_bytes", nb[0], 25 + 2048);
    check("a_frame2_data", frame_errs(0, 1049), 0);
    check("a_protocol_viol", viol[0], 0);
    done_a = 1'b1;
  end

  // Instance B: slower SCLK, byte period and whole-frame length
  initial begin : scen_b
    int n, c0;
    rst_n_b = 1'b0;
    st_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_b = 1'b1;
    n = 0;
    while (busy[1] && n < 3000) begin @(negedge clk); n++; end
    check("b_init_idle", 32'(busy[1]), 0);
    check("b_init_count", nb[1], 25);
    check("b_init_period", bt[1][1] - bt[1][0], 66);
    st_b = 1'b1; @(negedge clk); st_b = 1'b0;
    check("b_cs_fall", 32'(cs_n[1]), 0);
    c0 = cyc;
    n = 0;
    while (!cs_n[1] && n < 70000) begin @(negedge clk); n++; end
    check("b_frame_cycles", cyc - c0, 67584);
    repeat (5) @(negedge clk);
    check("b_frame_done", nfd[1], 1);
    check("b_frame_bytes", nb[1], 25 + 1024);
    check("b_frame_period", bt[1][26] - bt[1][25], 66);
    check("b_frame_data", frame_errs(1, 25), 0);
    check("b_protocol_viol", viol[1], 0);
    done_b = 1'b1;
  end

  // Instance C: reset at byte 500 bit 3, clean re-init, counter restarts
  initial begin : scen_c
    int n, base;
    rst_n_c = 1'b0;
    st_c = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_c = 1'b1;
    n = 0;
    while (busy[2] && n < 2000) begin @(negedge clk); n++; end
    st_c = 1'b1; @(negedge clk); st_c = 1'b0;
    n = 0;
    while (!(nb[2] == 525 && bitn[2] == 3) && n < 20000) begin @(negedge clk); n++; end
    check("c_bc_before_abort", 32'(bc[2]), 500);
    rst_n_c = 1'b0;
    #1;
    check("c_abort_outs", 32'({bc[2], busy[2], fd[2], sclk[2], mosi[2], cs_n[2], dc[2], res_n[2]}), RST_OUTS);
    base = nb[2];
    repeat (3) @(negedge clk);
    rst_n_c = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!res_n[2] && n < 100);
    check("c_res_low_cycles", n, 10);
    n = 0;
    while (busy[2] && n < 2000) begin @(negedge clk); n++; end
    check("c_reinit_count", nb[2] - base, 25);
    check("c_reinit_first", 32'(bv[2][base]), 32'hAE);
    check("c_reinit_last", 32'(bv[2][base + 24]), 32'hAF);
    check("c_no_frame_done", nfd[2], 0);
    st_c = 1'b1; @(negedge clk); st_c = 1'b0;
    check("c_bc_restart", 32'({bc[2], cs_n[2]}), 0);
    n = 0;
    while (nb[2] < base + 26 && n < 200) begin @(negedge clk); n++; end
    check("c_first_byte", 32'({bd[2][base + 25], bv[2][base + 25]}), 32'h100);
    check("c_protocol_viol", viol[2], 0);
    done_c = 1'b1;
  end

  initial begin : finish_blk
    int n;
    n = 0;
    while (!(done_a && done_b && done_c) && n < 90000) begin @(posedge clk); n++; end
    check("all_scenarios_finished", 32'({done_a, done_b, done_c}), 32'b111);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
